// File: rtl/mem_pkg.sv
// Shared definitions for the ROM/RAM memory subsystem: region decode,
// arbitration states and the fixed ROM contents.
package mem_pkg;

    typedef enum logic [1:0] {
        REGION_ROM  = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_NONE = 2'd2
    } region_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Classifies a byte address. The ROM starts at address 0, the RAM at
    // ram_base; 33-bit arithmetic keeps the region ends from wrapping.
    function automatic region_t region_of(input logic [31:0] addr,
                                          input int          rom_aw,
                                          input int          ram_aw,
                                          input logic [31:0] ram_base);
        logic [32:0] rom_end;
        logic [32:0] ram_end;
        rom_end = 33'd4 << rom_aw;
        ram_end = {1'b0, ram_base} + (33'd4 << ram_aw);
        if ({1'b0, addr} < rom_end)
            return REGION_ROM;
        if ((addr >= ram_base) && ({1'b0, addr} < ram_end))
            return REGION_RAM;
        return REGION_NONE;
    endfunction

    // ROM image as a pure function of the word index, so the ROM needs
    // no load step and is identical in every build.
    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        return {idx[15:0] ^ idx[31:16] ^ 16'hA5C3, ~idx[15:0]};
    endfunction

endpackage

// File: rtl/mem_rom_ram_if.sv
// Request/response bundle between the core (master) and the memory
// subsystem (slave).
interface mem_rom_ram_if;
    logic        MEM_WAIT;
    logic        INST_RDEN;
    logic [31:0] INST_RIADDR;
    logic [31:0] INST_ROADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        DATA_RDEN;
    logic [31:0] DATA_RIADDR;
    logic [31:0] DATA_ROADDR;
    logic        DATA_RVALID;
    logic [31:0] DATA_RDATA;
    logic        DATA_WREN;
    logic [3:0]  DATA_WSTRB;
    logic [31:0] DATA_WADDR;
    logic [31:0] DATA_WDATA;

    modport master (
        input  MEM_WAIT, INST_ROADDR, INST_RVALID, INST_RDATA,
               DATA_ROADDR, DATA_RVALID, DATA_RDATA,
        output INST_RDEN, INST_RIADDR, DATA_RDEN, DATA_RIADDR,
               DATA_WREN, DATA_WSTRB, DATA_WADDR, DATA_WDATA
    );

    modport slave (
        output MEM_WAIT, INST_ROADDR, INST_RVALID, INST_RDATA,
               DATA_ROADDR, DATA_RVALID, DATA_RDATA,
        input  INST_RDEN, INST_RIADDR, DATA_RDEN, DATA_RIADDR,
               DATA_WREN, DATA_WSTRB, DATA_WADDR, DATA_WDATA
    );
endinterface

// File: rtl/ram_singleport_be.sv
// Single-port RAM: one read or one byte-strobed write per cycle,
// registered read data that holds until the next read.
module ram_singleport_be #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            strb,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // Write only the byte lanes whose strobe bit is set.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i])
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Registered read; the port is shared, so no read during a write.
    always_ff @(posedge clk) begin
        if (en && !we)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/rom_dualport.sv
// Dual-port ROM with registered reads; both ports may read every cycle.
module rom_dualport
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [31:0]           rdata_a,
    output logic [31:0]           rdata_b
);

    // Both ports return the addressed ROM word one cycle later.
    always_ff @(posedge clk) begin
        rdata_a <= rom_word(32'(addr_a));
        rdata_b <= rom_word(32'(addr_b));
    end

endmodule

// File: rtl/mem_rom_ram.sv
// Instruction/data memory: address decode into ROM, RAM or unmapped space,
// with arbitration of the single RAM port and a stall while losers drain.
module mem_rom_ram
    import mem_pkg::*;
#(
    parameter int          ROM_ADDR_WIDTH = 10,
    parameter int          RAM_ADDR_WIDTH = 10,
    parameter logic [31:0] RAM_BASE       = 32'h0001_0000
) (
    input  logic          CLK,
    input  logic          RST,
    mem_rom_ram_if.slave  bus
);

    region_t inst_reg, rd_reg, wr_reg;
    logic    inst_ram, rd_ram, wr_ram;
    logic [1:0] ram_req_cnt;
    logic    conflict;
    state_t  state;

    logic                      pend_wr_valid;
    logic [RAM_ADDR_WIDTH-1:0] pend_wr_idx;
    logic [3:0]                pend_wr_strb;
    logic [31:0]               pend_wr_data;
    logic                      pend_rd_valid;
    logic [31:0]               pend_rd_addr;

    logic                      ram_en, ram_we;
    logic [3:0]                ram_strb;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]               ram_wdata, ram_rdata;
    logic [31:0]               rom_rdata_a, rom_rdata_b;

    logic        inst_serve, data_serve;
    logic [31:0] data_rd_addr;
    region_t     data_rd_reg;

    logic        inst_rvalid, data_rvalid;
    logic [31:0] inst_roaddr, data_roaddr;
    region_t     inst_src, data_src;

    assign inst_reg = region_of(bus.INST_RIADDR, ROM_ADDR_WIDTH, RAM_ADDR_WIDTH, RAM_BASE);
    assign rd_reg   = region_of(bus.DATA_RIADDR, ROM_ADDR_WIDTH, RAM_ADDR_WIDTH, RAM_BASE);
    assign wr_reg   = region_of(bus.DATA_WADDR,  ROM_ADDR_WIDTH, RAM_ADDR_WIDTH, RAM_BASE);

    assign inst_ram    = bus.INST_RDEN && (inst_reg == REGION_RAM);
    assign rd_ram      = bus.DATA_RDEN && (rd_reg == REGION_RAM);
    assign wr_ram      = bus.DATA_WREN && (wr_reg == REGION_RAM);
    assign ram_req_cnt = {1'b0, inst_ram} + {1'b0, rd_ram} + {1'b0, wr_ram};
    assign conflict    = (state == ST_IDLE) && (ram_req_cnt >= 2'd2);
    assign bus.MEM_WAIT = (state == ST_STALL) || conflict;

    // Instructions are only served in IDLE and always win the RAM port.
    // A data read is served now unless it lost the RAM to a higher
    // priority request; in STALL it is served once the pending write is done.
    assign inst_serve   = (state == ST_IDLE) && bus.INST_RDEN;
    assign data_serve   = (state == ST_IDLE)
                        ? (bus.DATA_RDEN && (!rd_ram || (!inst_ram && !wr_ram)))
                        : (!pend_wr_valid && pend_rd_valid);
    assign data_rd_addr = (state == ST_IDLE) ? bus.DATA_RIADDR : pend_rd_addr;
    assign data_rd_reg  = (state == ST_IDLE) ? rd_reg : REGION_RAM;

    // Route the single RAM port to the winning request; writes are
    // suppressed during reset so a discarded pending write never lands.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_strb  = 4'h0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state == ST_IDLE) begin
            if (inst_ram) begin
                ram_en   = 1'b1;
                ram_addr = bus.INST_RIADDR[RAM_ADDR_WIDTH+1:2];
            end else if (wr_ram) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_strb  = bus.DATA_WSTRB;
                ram_addr  = bus.DATA_WADDR[RAM_ADDR_WIDTH+1:2];
                ram_wdata = bus.DATA_WDATA;
            end else if (rd_ram) begin
                ram_en   = 1'b1;
                ram_addr = bus.DATA_RIADDR[RAM_ADDR_WIDTH+1:2];
            end
        end else if (pend_wr_valid) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_strb  = pend_wr_strb;
            ram_addr  = pend_wr_idx;
            ram_wdata = pend_wr_data;
        end else if (pend_rd_valid) begin
            ram_en   = 1'b1;
            ram_addr = pend_rd_addr[RAM_ADDR_WIDTH+1:2];
        end
        if (RST) begin
            ram_en = 1'b0;
            ram_we = 1'b0;
        end
    end

    rom_dualport #(.ADDR_WIDTH(ROM_ADDR_WIDTH)) u_rom (
        .clk     (CLK),
        .addr_a  (bus.INST_RIADDR[ROM_ADDR_WIDTH+1:2]),
        .addr_b  (data_rd_addr[ROM_ADDR_WIDTH+1:2]),
        .rdata_a (rom_rdata_a),
        .rdata_b (rom_rdata_b)
    );

    ram_singleport_be #(.ADDR_WIDTH(RAM_ADDR_WIDTH)) u_ram (
        .clk   (CLK),
        .en    (ram_en),
        .we    (ram_we),
        .strb  (ram_strb),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Arbitration FSM: on a conflict park the losers, then drain them
    // write-first, one per cycle, returning to IDLE with the last one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            pend_wr_valid <= 1'b0;
            pend_wr_idx   <= '0;
            pend_wr_strb  <= 4'h0;
            pend_wr_data  <= '0;
            pend_rd_valid <= 1'b0;
            pend_rd_addr  <= '0;
        end else if (state == ST_IDLE) begin
            if (conflict) begin
                state         <= ST_STALL;
                pend_wr_valid <= wr_ram && inst_ram;
                pend_wr_idx   <= bus.DATA_WADDR[RAM_ADDR_WIDTH+1:2];
                pend_wr_strb  <= bus.DATA_WSTRB;
                pend_wr_data  <= bus.DATA_WDATA;
                pend_rd_valid <= rd_ram && (inst_ram || wr_ram);
                pend_rd_addr  <= bus.DATA_RIADDR;
            end
        end else if (pend_wr_valid) begin
            pend_wr_valid <= 1'b0;
            if (!pend_rd_valid)
                state <= ST_IDLE;
        end else begin
            pend_rd_valid <= 1'b0;
            state         <= ST_IDLE;
        end
    end

    // Response side: one-cycle valid pulses, echoed request addresses and
    // the source region used to pick the returned word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inst_rvalid <= 1'b0;
            inst_roaddr <= '0;
            inst_src    <= REGION_NONE;
            data_rvalid <= 1'b0;
            data_roaddr <= '0;
            data_src    <= REGION_NONE;
        end else begin
            inst_rvalid <= inst_serve;
            inst_src    <= inst_serve ? inst_reg : REGION_NONE;
            if (inst_serve)
                inst_roaddr <= bus.INST_RIADDR;
            data_rvalid <= data_serve;
            data_src    <= data_serve ? data_rd_reg : REGION_NONE;
            if (data_serve)
                data_roaddr <= data_rd_addr;
        end
    end

    // Select returned data by source; unmapped and idle return zero.
    always_comb begin
        bus.INST_RDATA = '0;
        bus.DATA_RDATA = '0;
        case (inst_src)
            REGION_ROM: bus.INST_RDATA = rom_rdata_a;
            REGION_RAM: bus.INST_RDATA = ram_rdata;
            default:    bus.INST_RDATA = '0;
        endcase
        case (data_src)
            REGION_ROM: bus.DATA_RDATA = rom_rdata_b;
            REGION_RAM: bus.DATA_RDATA = ram_rdata;
            default:    bus.DATA_RDATA = '0;
        endcase
    end

    assign bus.INST_RVALID = inst_rvalid;
    assign bus.INST_ROADDR = inst_roaddr;
    assign bus.DATA_RVALID = data_rvalid;
    assign bus.DATA_ROADDR = data_roaddr;

endmodule

// File: doc/mem_rom_ram.md
Name: mem_rom_ram

Overview:
Next-generation instruction/data memory subsystem with parametrised ROM and RAM regions.
- Decodes each access by address into a dual-port ROM, a single-port byte-writable RAM, or unmapped space.
- Arbitrates RAM-port conflicts between the instruction and data channels, stalling the pipeline through MEM_WAIT.
- Sits between core fetch/LSU stages and on-chip storage; replaces the ROM-only memory.

Parameters:
- ROM_ADDR_WIDTH, 10, ROM depth = 2^ROM_ADDR_WIDTH 32-bit words; ROM at byte address 0.
- RAM_ADDR_WIDTH, 10, RAM depth = 2^RAM_ADDR_WIDTH 32-bit words.
- RAM_BASE, 32'h0001_0000, RAM byte base address; must be aligned to 4*2^RAM_ADDR_WIDTH and above the ROM end.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- MEM_WAIT  out  1  pipeline stall; while high, requesters hold their inputs.
- INST_RDEN  in  1  instruction read request.
- INST_RIADDR  in  32  instruction byte address.
- INST_ROADDR  out  32  address of the returned instruction.
- INST_RVALID  out  1  instruction data valid.
- INST_RDATA  out  32  instruction word.
- DATA_RDEN  in  1  data read request.
- DATA_RIADDR  in  32  data read byte address.
- DATA_ROADDR  out  32  address of the returned data.
- DATA_RVALID  out  1  read data valid.
- DATA_RDATA  out  32  read data word.
- DATA_WREN  in  1  data write request.
- DATA_WSTRB  in  4  byte enables; bit i enables byte lane [8i+7:8i].
- DATA_WADDR  in  32  write byte address.
- DATA_WDATA  in  32  write data.

Behaviour:
- Address decode:
  - ROM region: addr < 4*2^ROM_ADDR_WIDTH.
  - RAM region: RAM_BASE <= addr < RAM_BASE + 4*2^RAM_ADDR_WIDTH.
  - Everything else is unmapped.
  - Word index = addr[ADDR_WIDTH+1:2]; addr[1:0] ignored.
- Read latency is 1 cycle from the cycle the request is served. RVALID pulses for one cycle. ROADDR echoes the full 32-bit request address.
- The ROM is dual-ported: instruction and data ROM reads in the same cycle never conflict.
- The RAM is single-ported: one access per cycle.
  - Priority: INST read > DATA write > DATA read.
  - Writes apply WSTRB lanes at the clock edge of the cycle they are served.
- Writes to ROM or unmapped space are dropped silently; no stall is generated.
- Unmapped reads return RDATA=0, RVALID=1 after 1 cycle, with no stall.
- State machine IDLE / STALL, with pending registers pend_wr (addr, strb, data) and pend_rd (addr):
  - IDLE, no RAM conflict: serve all requests; stay in IDLE; MEM_WAIT=0.
  - IDLE, two or more requests target RAM: serve the highest-priority one; latch the losers into the pending registers; MEM_WAIT=1 combinationally this cycle; go to STALL.
  - STALL: new inputs are ignored. Serve one pending per cycle, pend_wr before pend_rd. MEM_WAIT=1. Return to IDLE in the cycle the last pending is served, so MEM_WAIT=0 the following cycle.
- Read-after-write ordering: a deferred DATA read to the same address as a deferred write returns the written data.
- Same-cycle DATA read and write to the same RAM word: the write is served first, so the read returns the new data one cycle later.
- Reset values:
  - MEM_WAIT, INST_RVALID, DATA_RVALID = 0.
  - INST/DATA_RDATA and INST/DATA_ROADDR = 0.
  - State = IDLE; pending registers cleared.
  - RAM and ROM contents are not cleared.
- RST asserted during STALL discards all pending requests, including any unperformed write.

Decomposition:
- Shared package mem_pkg holds:
  - Region-decode enum (REGION_ROM, REGION_RAM, REGION_NONE).
  - Arbitration state enum (ST_IDLE, ST_STALL).
  - Pure decode function region_of(addr, params).
- Existing rom_dualport is reused for the ROM.
- One new sub-module, ram_singleport_be: 1R/1W shared-port RAM with byte strobes, registered read, parameter ADDR_WIDTH.

Test Plan:
- Cycle 0: INST read 0x0000_0010 (ROM) and DATA read 0x0000_0020 (ROM) -> cycle 1: both RVALID=1 with the ROM words; MEM_WAIT never asserted.
- DATA write 0x0001_0004, WSTRB=4'b0101, WDATA=0xAABBCCDD over a word previously holding 0x11223344; then read it -> RDATA=0x11BB33DD.
- Cycle 0: INST read 0x0001_0000 (RAM) and DATA read 0x0001_0008 (RAM) -> INST_RVALID at cycle 1; DATA_RVALID at cycle 2 with DATA_ROADDR=0x0001_0008; MEM_WAIT=1 in cycles 0-1, 0 in cycle 2.
- Cycle 0: INST read, DATA write 0x0001_000C=0xDEADBEEF (WSTRB=4'hF) and DATA read 0x0001_000C, all to RAM -> write performed at cycle 1; DATA_RVALID at cycle 3 with 0xDEADBEEF; MEM_WAIT=1 in cycles 0-2.
- DATA read 0x8000_0000 (unmapped) -> DATA_RVALID=1, DATA_RDATA=0 next cycle; write to 0x0000_0004 (ROM) leaves the ROM word unchanged; MEM_WAIT stays 0.
- Create the scenario-4 conflict, then assert RST in cycle 1 -> all outputs 0 next cycle; state IDLE; RAM word 0x0001_000C retains its old value.
